// File: rtl/router_xbar.sv
`default_nettype none
// ============================================================================
// Module   : router_xbar
// Purpose  : NUM_PORTS x NUM_PORTS crossbar router with per-input FIFOs and
//            round-robin arbitration into registered valid/ready outputs.
//            Define ROUTER_XBAR_STATS_EN to add per-output handshake counters.
// Revision : 1.0 - initial release
// ============================================================================
module router_xbar #(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]        in_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]        in_data,
    input  logic [NUM_PORTS-1:0]                   in_valid,
    output logic [NUM_PORTS-1:0]                   in_ready,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]        out_data,
    output logic [NUM_PORTS*$clog2(NUM_PORTS)-1:0] out_src,
    output logic [NUM_PORTS-1:0]                   out_valid,
    input  logic [NUM_PORTS-1:0]                   out_ready
`ifdef ROUTER_XBAR_STATS_EN
    ,
    input  logic                                   stat_clear,
    output logic [NUM_PORTS*16-1:0]                stat_count
`endif
);

    localparam int PORT_BITS = $clog2(NUM_PORTS);
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int CNT_W     = PTR_W + 1;

    logic [NUM_PORTS-1:0]  w_push;
    logic [NUM_PORTS-1:0]  w_pop;
    logic [NUM_PORTS-1:0]  w_full;
    logic [NUM_PORTS-1:0]  w_nonempty;
    logic [DATA_WIDTH-1:0] w_head_data [NUM_PORTS];
    logic [PORT_BITS-1:0]  w_head_dest [NUM_PORTS];
    logic [NUM_PORTS-1:0]  w_gnt_vld;
    logic [PORT_BITS-1:0]  w_gnt_idx [NUM_PORTS];

    // Only the destination bits of the address are routed; the rest is dropped.
    logic w_unused_addr;
    assign w_unused_addr = ^in_addr;

    assign in_ready = ~w_full;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_fifo
        logic [DATA_WIDTH-1:0] data_mem_q [FIFO_DEPTH];
        logic [PORT_BITS-1:0]  dest_mem_q [FIFO_DEPTH];
        logic [PTR_W-1:0]      wr_ptr_q;
        logic [PTR_W-1:0]      rd_ptr_q;
        logic [CNT_W-1:0]      count_q;
        logic [CNT_W-1:0]      count_d;

        assign w_full[i]      = (count_q == CNT_W'(FIFO_DEPTH));
        assign w_nonempty[i]  = (count_q != '0);
        assign w_push[i]      = in_valid[i] && !w_full[i];
        assign w_head_data[i] = data_mem_q[rd_ptr_q];
        assign w_head_dest[i] = dest_mem_q[rd_ptr_q];

        always_comb begin
            count_d = count_q;
            case ({w_push[i], w_pop[i]})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                count_q <= count_d;
                if (w_push[i]) begin
                    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                end
                if (w_pop[i]) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
            end
        end

        // Storage is qualified by the pointers, so it needs no reset.
        always_ff @(posedge clk) begin
            if (w_push[i]) begin
                data_mem_q[wr_ptr_q] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
                dest_mem_q[wr_ptr_q] <= in_addr[i*ADDR_WIDTH +: PORT_BITS];
            end
        end
    end

    // Each head targets a single output, so at most one grant can name it.
    always_comb begin
        w_pop = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (w_gnt_vld[o]) begin
                w_pop[w_gnt_idx[o]] = 1'b1;
            end
        end
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
        logic [DATA_WIDTH-1:0] data_q;
        logic [PORT_BITS-1:0]  src_q;
        logic                  valid_q;
        logic [PORT_BITS-1:0]  rr_q;
        logic                  can_load;
        logic                  found;
        logic [PORT_BITS-1:0]  sel;

        assign can_load = !valid_q || out_ready[o];

        // Descending scan so the last hit is the nearest requester at or above rr_q.
        always_comb begin
            logic [PORT_BITS-1:0] idx;
            idx   = '0;
            found = 1'b0;
            sel   = '0;
            for (int k = NUM_PORTS - 1; k >= 0; k--) begin
                idx = rr_q + PORT_BITS'(k);
                if (w_nonempty[idx] && (w_head_dest[idx] == PORT_BITS'(o))) begin
                    found = 1'b1;
                    sel   = idx;
                end
            end
        end

        assign w_gnt_vld[o] = can_load && found;
        assign w_gnt_idx[o] = sel;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                data_q  <= '0;
                src_q   <= '0;
                valid_q <= 1'b0;
                rr_q    <= '0;
            end else if (can_load) begin
                if (found) begin
                    data_q  <= w_head_data[sel];
                    src_q   <= sel;
                    valid_q <= 1'b1;
                    rr_q    <= sel + PORT_BITS'(1);
                end else if (out_ready[o]) begin
                    valid_q <= 1'b0;
                end
            end
        end

        assign out_data[o*DATA_WIDTH +: DATA_WIDTH] = data_q;
        assign out_src[o*PORT_BITS +: PORT_BITS]    = src_q;
        assign out_valid[o]                         = valid_q;

`ifdef ROUTER_XBAR_STATS_EN
        logic [15:0] stat_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                stat_q <= '0;
            end else if (stat_clear) begin
                stat_q <= '0;
            end else if (valid_q && out_ready[o] && (stat_q != 16'hFFFF)) begin
                stat_q <= stat_q + 16'd1;
            end
        end

        assign stat_count[o*16 +: 16] = stat_q;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_router_xbar.sv
`default_nettype none
// ============================================================================
// Module   : tb_router_xbar
// Purpose  : Self-checking bench for router_xbar (scoreboard per src/dst pair).
// Revision : 1.0 - initial release
// ============================================================================
module tb_router_xbar;

    localparam int NP = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int PB = 2;

    logic             clk      = 1'b0;
    logic             reset_n  = 1'b0;
    logic [NP*AW-1:0] in_addr  = '0;
    logic [NP*DW-1:0] in_data  = '0;
    logic [NP-1:0]    in_valid = '0;
    logic [NP-1:0]    in_ready;
    logic [NP*DW-1:0] out_data;
    logic [NP*PB-1:0] out_src;
    logic [NP-1:0]    out_valid;
    logic [NP-1:0]    out_ready = '1;
`ifdef ROUTER_XBAR_STATS_EN
    logic             stat_clear = 1'b0;
    logic [NP*16-1:0] stat_count;
`endif

    router_xbar #(
        .NUM_PORTS  (NP),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef ROUTER_XBAR_STATS_EN
        ,
        .stat_clear(stat_clear),
        .stat_count(stat_count)
`endif
    );

    always #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW-1:0] sb [NP*NP][$];
    int            dlv [NP*NP];
    int            seq [NP];
    logic          rdy_drop;
    logic          log_en = 1'b0;
    logic [PB-1:0] src_log [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sb_total();
        int t = 0;
        for (int k = 0; k < NP*NP; k++) t += sb[k].size();
        return t;
    endfunction

    function automatic int dlv_total();
        int t = 0;
        for (int k = 0; k < NP*NP; k++) t += dlv[k];
        return t;
    endfunction

    // Monitor: retire deliveries against the scoreboard, then record acceptances.
    always @(negedge clk) begin
        int            s;
        int            key;
        logic [DW-1:0] exp_d;
        if (reset_n) begin
            for (int o = 0; o < NP; o++) begin
                if (out_valid[o] && out_ready[o]) begin
                    s   = int'(out_src[o*PB +: PB]);
                    key = s*NP + o;
                    dlv[key]++;
                    if (log_en && o == 1) src_log.push_back(out_src[o*PB +: PB]);
                    check("sb_has_word", 64'(sb[key].size() != 0), 64'd1);
                    if (sb[key].size() != 0) begin
                        exp_d = sb[key].pop_front();
                        check("out_data", 64'(out_data[o*DW +: DW]), 64'(exp_d));
                    end
                end
            end
            for (int i = 0; i < NP; i++) begin
                if (in_valid[i] && in_ready[i]) begin
                    key = i*NP + int'(in_addr[i*AW +: PB]);
                    sb[key].push_back(in_data[i*DW +: DW]);
                end
            end
        end
    end

    // Streams words from the enabled inputs; a new word is presented after each acceptance.
    task automatic run_streams(input int cycles, input logic [NP-1:0] en,
                               input logic [2*NP-1:0] dsts, input logic [7:0] tag);
        logic [NP-1:0] acc;
        logic [31:0]   r;
        for (int i = 0; i < NP; i++) seq[i] = 0;
        rdy_drop = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            for (int i = 0; i < NP; i++) begin
                r = $urandom();
                in_addr[i*AW +: AW] = {r[AW-1:PB], dsts[i*2 +: 2]};
                in_data[i*DW +: DW] = {tag, 8'(i), 16'(seq[i])};
            end
            in_valid = en;
            @(negedge clk);
            acc = in_valid & in_ready;
            if ((en & ~in_ready) != '0) rdy_drop = 1'b1;
            @(posedge clk);
            #1;
            for (int i = 0; i < NP; i++) if (acc[i]) seq[i]++;
        end
        in_valid = '0;
    endtask

    task automatic wait_drain(input int max_cyc);
        int c = 0;
        while ((sb_total() != 0 || out_valid != '0) && c < max_cyc) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("drain_done", 64'(sb_total() == 0 && out_valid == '0), 64'd1);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PB-1:0] pat [3];
        int            cnt [NP];
        int            base;
        int            base_arr [NP];
        pat[0] = 2'd0;
        pat[1] = 2'd1;
        pat[2] = 2'd3;
        for (int k = 0; k < NP*NP; k++) dlv[k] = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_out_data", 64'(out_data[63:0]), 64'h0);
        check("rst_out_src", 64'(out_src), 64'h0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_in_ready", 64'(in_ready), 64'hF);

        // Single word 0 -> 2, one cycle latency
        in_addr[0 +: AW] = 32'h0000_0002;
        in_data[0 +: DW] = 32'hA5A5_0001;
        in_valid         = 4'b0001;
        @(posedge clk);
        #1;
        in_valid = '0;
        check("single_not_yet", 64'(out_valid), 64'h0);
        @(posedge clk);
        #1;
        check("single_valid", 64'(out_valid), 64'h4);
        check("single_data", 64'(out_data[2*DW +: DW]), 64'hA5A5_0001);
        check("single_src", 64'(out_src[2*PB +: PB]), 64'h0);
        wait_drain(20);

        // Contention: inputs 0,1,3 -> output 1
        src_log.delete();
        log_en = 1'b1;
        run_streams(40, 4'b1011, 8'b01_01_01_01, 8'h02);
        log_en = 1'b0;
        check("rr_log_len", 64'(src_log.size() >= 30), 64'd1);
        for (int i = 0; i < NP; i++) cnt[i] = 0;
        for (int k = 0; k < 30 && k < src_log.size(); k++) begin
            check("rr_order", 64'(src_log[k]), 64'(pat[k % 3]));
            cnt[int'(src_log[k])]++;
        end
        check("rr_share_0", 64'(cnt[0]), 64'd10);
        check("rr_share_1", 64'(cnt[1]), 64'd10);
        check("rr_share_3", 64'(cnt[3]), 64'd10);
        wait_drain(100);

        // Backpressure: input 2 -> output 3 with sink stalled
        base      = dlv[2*NP + 3];
        out_ready = 4'b0111;
        run_streams(12, 4'b0100, 8'b11_11_11_11, 8'h03);
        check("bp_accepted", 64'(seq[2]), 64'd5);
        check("bp_in_ready", 64'(in_ready[2]), 64'd0);
        check("bp_valid", 64'(out_valid[3]), 64'd1);
        check("bp_data", 64'(out_data[3*DW +: DW]), 64'h0302_0000);
        check("bp_src", 64'(out_src[3*PB +: PB]), 64'd2);
        repeat (3) @(posedge clk);
        #1;
        check("bp_data_held", 64'(out_data[3*DW +: DW]), 64'h0302_0000);
        out_ready = '1;
        wait_drain(50);
        check("bp_delivered", 64'(dlv[2*NP + 3] - base), 64'd5);

        // Parallel disjoint: input i -> output (i+1)%4
        for (int i = 0; i < NP; i++) base_arr[i] = dlv[i*NP + ((i + 1) % NP)];
        run_streams(20, 4'hF, 8'b00_11_10_01, 8'h04);
        check("par_all_valid", 64'(out_valid), 64'hF);
        check("par_no_ready_drop", 64'(rdy_drop), 64'd0);
        for (int i = 0; i < NP; i++) check("par_accepted", 64'(seq[i]), 64'd20);
        wait_drain(50);
        for (int i = 0; i < NP; i++)
            check("par_delivered", 64'(dlv[i*NP + ((i + 1) % NP)] - base_arr[i]), 64'd20);

        // Reset mid-operation
        out_ready = '0;
        run_streams(3, 4'hF, 8'b00_11_10_01, 8'h05);
        check("mid_pre_valid", 64'(out_valid), 64'hF);
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'h0);
        check("mid_rst_data", 64'(out_data[63:0]), 64'h0);
        for (int k = 0; k < NP*NP; k++) sb[k].delete();
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("mid_in_ready", 64'(in_ready), 64'hF);
        base      = dlv_total();
        out_ready = '1;
        repeat (10) @(posedge clk);
        #1;
        check("mid_no_stale", 64'(dlv_total() - base), 64'd0);
        check("mid_valid_low", 64'(out_valid), 64'h0);

`ifdef ROUTER_XBAR_STATS_EN
        // Counter saturation and clear priority
        run_streams(70010, 4'b0001, 8'b00_00_00_00, 8'h06);
        check("stat_saturate", 64'(stat_count[15:0]), 64'hFFFF);
        wait_drain(50);
        out_ready = 4'b1110;
        run_streams(3, 4'b0001, 8'b00_00_00_00, 8'h07);
        out_ready  = '1;
        stat_clear = 1'b1;
        @(posedge clk);
        #1;
        check("stat_clear_wins", 64'(stat_count[15:0]), 64'h0);
        stat_clear = 1'b0;
        @(posedge clk);
        #1;
        check("stat_after_clear", 64'(stat_count[15:0]), 64'h1);
        wait_drain(50);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
